mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage access controller. Sits directly downstream of the EX/MEM pipeline register.
- Takes the registered ALU result as the address, plus store data, MemRead/MemWrite/Word/RegWrite and Rd.
- Runs a variable-latency req/ack transaction to data memory, with byte-lane steering.
- Stalls the upstream pipeline while an access is in flight and presents load data and writeback controls to the MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in BUSY waiting for memAck before the bus-error abort.
- SIGN_EXT_BYTE, 1: 1 = byte loads sign-extend bit 7; 0 = zero-extend.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- inAddress  in  32  byte address (EX/MEM result)
- inStoreData  in  32  store data (EX/MEM read register 2)
- inMemRead  in  1  load request
- inMemWrite  in  1  store request
- inWord  in  1  1 = word access, 0 = byte access
- inRegWrite  in  1  writeback enable from EX/MEM
- inRd  in  5  destination register
- memReq  out  1  memory request, held until ack or abort
- memWe  out  1  1 = write
- memAddr  out  32  word-aligned address, {inAddress[31:2],2'b00}
- memWData  out  32  write data
- memByteEn  out  4  byte-lane enables
- memAck  in  1  one-cycle completion pulse
- memRData  in  32  read data, valid with memAck
- stall  out  1  freezes PC/IF/ID/ID-EX/EX-MEM
- outValid  out  1  MEM/WB may capture this cycle
- outLoadData  out  32  aligned/extended load data
- outResult  out  32  pass-through of inAddress
- outRd  out  5  pass-through of inRd
- outRegWrite  out  1  gated writeback enable
- outMisaligned  out  1  word access with inAddress[1:0]!=0
- outBusError  out  1  timeout abort flag

Behaviour:
- Reset, async, reset low:
  - state=IDLE, counter=0.
  - memReq/memWe=0, memByteEn=0, memAddr/memWData=0, outLoadData=0, outBusError=0.
  - Reset taken mid-transaction drops memReq immediately; a later memAck is ignored.
- access = (inMemRead|inMemWrite) & !outMisaligned.
- outMisaligned = (inMemRead|inMemWrite) & inWord & (inAddress[1:0]!=0). No request is issued, no stall, outRegWrite forced 0.
- Read and write both asserted: treated as write (memWe=1), outRegWrite forced 0.
- FSM states IDLE, BUSY, DONE:
  - IDLE: non-memory instruction → stall=0, outValid=1, one-cycle stage. If access → stall=1, outValid=0; next edge: register memReq=1, memWe, memAddr, memWData, memByteEn; counter=0; go BUSY.
  - BUSY: stall=1, outValid=0, memReq held, address/data stable. memAck → latch outLoadData, memReq=0, go DONE. Otherwise counter++. Reaching TIMEOUT_CYCLES-1 without ack → memReq=0, outBusError=1, outLoadData=0, go DONE. memAck and timeout in the same cycle: ack wins.
  - DONE: stall=0, outValid=1. Held instruction is consumed at this edge, and EX/MEM advances. Go IDLE unconditionally; outBusError clears on leaving DONE. Inputs in DONE are the completed instruction and must not restart an access.
- Latency:
  - Non-memory instruction: 0 extra cycles.
  - Memory access: 1 (issue) + N (ack wait, N≥1) + 1 (DONE) cycles.
- outRegWrite = inRegWrite & !outMisaligned & !(outBusError in DONE) & !memWe-path.
- Store lanes:
  - Word: memByteEn=4'b1111, memWData=inStoreData.
  - Byte: memByteEn=4'b0001<<inAddress[1:0], memWData={4{inStoreData[7:0]}}.
- Load lanes:
  - Word: outLoadData=memRData.
  - Byte: lane k=inAddress[1:0] selects memRData[8k+7:8k], extended per SIGN_EXT_BYTE.
- memAck seen in IDLE or DONE is ignored.
- Counter is 8 bits wide; TIMEOUT_CYCLES must be between 2 and 255.

Decomposition:
- Shared package (pipeline_pkg):
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - Control-bit indices of the EX/MEM bundle (MemRead=2, MemWrite=4, RegWrite=6, Word=8).
  - Byte-lane width constants.
- One natural sub-module: byte_lane_align. A combinational lane steering/extension block used for both store replicate/enable and load select/extend.

Test Plan:
- Word load to 0x100, memAck after 3 cycles with memRData=0xDEADBEEF → memAddr=0x100, byteEn=1111, stall high for 5 cycles, DONE gives outLoadData=0xDEADBEEF, outRegWrite=1.
- Byte load to 0x103 with memRData=0x80FF0011, SIGN_EXT_BYTE=1 → outLoadData=0xFFFFFF80. Same with SIGN_EXT_BYTE=0 → 0x00000080.
- Byte store of 0x000000AB to 0x202 → memAddr=0x200, memByteEn=0100, memWData=0xABABABAB, memWe=1, outRegWrite=0.
- Word load to 0x106 → outMisaligned=1, memReq stays 0, stall=0, outRegWrite=0.
- No memAck with TIMEOUT_CYCLES=4 → memReq drops after 4 BUSY cycles, outBusError=1 for one cycle, outLoadData=0, then IDLE.
- reset low during BUSY → memReq=0 the same cycle, state IDLE. A memAck after release produces no DONE.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: MEM-stage FSM encoding, EX/MEM control-bit
// positions and byte-lane geometry.
package pipeline_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_REGWRITE = 6;
    localparam int CTRL_WORD     = 8;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;
    localparam int WORD_W = BYTE_W * LANES;

    function automatic logic [LANES-1:0] laneOneHot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational byte-lane steering: store replicate/enable on the way out,
// load lane select and sign/zero extension on the way back.
module byte_lane_align
    import pipeline_pkg::*;
#(
    parameter int SIGN_EXT_BYTE = 1
) (
    input  logic [1:0]        laneSel,
    input  logic              word,
    input  logic [WORD_W-1:0] storeData,
    input  logic [WORD_W-1:0] rawLoad,
    output logic [LANES-1:0]  byteEn,
    output logic [WORD_W-1:0] laneData,
    output logic [WORD_W-1:0] loadData
);

    logic [BYTE_W-1:0] pick;
    logic              extBit;

    always_comb begin
        pick = rawLoad[BYTE_W-1:0];
        case (laneSel)
            2'd0: pick = rawLoad[7:0];
            2'd1: pick = rawLoad[15:8];
            2'd2: pick = rawLoad[23:16];
            2'd3: pick = rawLoad[31:24];
            default: pick = rawLoad[7:0];
        endcase
        extBit   = (SIGN_EXT_BYTE != 0) ? pick[BYTE_W-1] : 1'b0;
        byteEn   = word ? {LANES{1'b1}} : laneOneHot(laneSel);
        laneData = word ? storeData : {LANES{storeData[BYTE_W-1:0]}};
        loadData = word ? rawLoad : {{(WORD_W-BYTE_W){extBit}}, pick};
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage access controller: issues one req/ack data-memory transaction per
// load/store, stalls upstream while it is in flight, and feeds MEM/WB.
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SIGN_EXT_BYTE  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inAddress,
    input  logic [31:0] inStoreData,
    input  logic        inMemRead,
    input  logic        inMemWrite,
    input  logic        inWord,
    input  logic        inRegWrite,
    input  logic [4:0]  inRd,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    output logic [3:0]  memByteEn,
    input  logic        memAck,
    input  logic [31:0] memRData,
    output logic        stall,
    output logic        outValid,
    output logic [31:0] outLoadData,
    output logic [31:0] outResult,
    output logic [4:0]  outRd,
    output logic        outRegWrite,
    output logic        outMisaligned,
    output logic        outBusError,
    output logic [1:0]  debugState
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [7:0]  counter;
    logic        memOp;
    logic        access;
    logic [3:0]  alignByteEn;
    logic [31:0] alignStoreData;
    logic [31:0] alignLoadData;

    assign memOp         = inMemRead | inMemWrite;
    assign outMisaligned = memOp & inWord & (inAddress[1:0] != 2'b00);
    assign access        = memOp & ~outMisaligned;

    byte_lane_align #(
        .SIGN_EXT_BYTE(SIGN_EXT_BYTE)
    ) laneAlign (
        .laneSel  (inAddress[1:0]),
        .word     (inWord),
        .storeData(inStoreData),
        .rawLoad  (memRData),
        .byteEn   (alignByteEn),
        .laneData (alignStoreData),
        .loadData (alignLoadData)
    );

    // Bus handshake: memReq rises with address/data/enables registered and
    // holds them stable until the cycle memAck is sampled high (or the
    // timeout aborts); memAck is a single-cycle pulse and memRData is only
    // meaningful in that cycle. Acks outside BUSY are dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            counter     <= 8'd0;
            memReq      <= 1'b0;
            memWe       <= 1'b0;
            memAddr     <= 32'd0;
            memWData    <= 32'd0;
            memByteEn   <= 4'd0;
            outLoadData <= 32'd0;
            outBusError <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        memReq    <= 1'b1;
                        memWe     <= inMemWrite;
                        memAddr   <= {inAddress[31:2], 2'b00};
                        memWData  <= alignStoreData;
                        memByteEn <= alignByteEn;
                        counter   <= 8'd0;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // An ack on the last allowed cycle still completes normally.
                    if (memAck) begin
                        outLoadData <= alignLoadData;
                        memReq      <= 1'b0;
                        state       <= ST_DONE;
                    end else if (counter == TIMEOUT_LAST) begin
                        memReq      <= 1'b0;
                        outBusError <= 1'b1;
                        outLoadData <= 32'd0;
                        state       <= ST_DONE;
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end
                ST_DONE: begin
                    outBusError <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stall       = ((state == ST_IDLE) & access) | (state == ST_BUSY);
    assign outValid    = ((state == ST_IDLE) & ~access) | (state == ST_DONE);
    assign outRegWrite = inRegWrite & ~outMisaligned & ~inMemWrite
                       & ~(outBusError & (state == ST_DONE));
    assign outResult   = inAddress;
    assign outRd       = inRd;
    assign debugState  = state;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int TO = 4;

  typedef struct packed {
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [3:0]  memByteEn;
    logic        stall;
    logic        outValid;
    logic [31:0] outLoadData;
    logic [31:0] outResult;
    logic [4:0]  outRd;
    logic        outRegWrite;
    logic        outMisaligned;
    logic        outBusError;
    logic [1:0]  dbg;
  } obs_t;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] inAddress = '0;
  logic [31:0] inStoreData = '0;
  logic        inMemRead = 1'b0;
  logic        inMemWrite = 1'b0;
  logic        inWord = 1'b0;
  logic        inRegWrite = 1'b0;
  logic [4:0]  inRd = '0;
  logic        memAck = 1'b0;
  logic [31:0] memRData = '0;

  obs_t obsA;
  obs_t obsB;

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .SIGN_EXT_BYTE(1)) dutA (
    .clock(clock), .reset(reset),
    .inAddress(inAddress), .inStoreData(inStoreData),
    .inMemRead(inMemRead), .inMemWrite(inMemWrite),
    .inWord(inWord), .inRegWrite(inRegWrite), .inRd(inRd),
    .memReq(obsA.memReq), .memWe(obsA.memWe), .memAddr(obsA.memAddr),
    .memWData(obsA.memWData), .memByteEn(obsA.memByteEn),
    .memAck(memAck), .memRData(memRData),
    .stall(obsA.stall), .outValid(obsA.outValid),
    .outLoadData(obsA.outLoadData), .outResult(obsA.outResult),
    .outRd(obsA.outRd), .outRegWrite(obsA.outRegWrite),
    .outMisaligned(obsA.outMisaligned), .outBusError(obsA.outBusError),
    .debugState(obsA.dbg)
  );

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .SIGN_EXT_BYTE(0)) dutB (
    .clock(clock), .reset(reset),
    .inAddress(inAddress), .inStoreData(inStoreData),
    .inMemRead(inMemRead), .inMemWrite(inMemWrite),
    .inWord(inWord), .inRegWrite(inRegWrite), .inRd(inRd),
    .memReq(obsB.memReq), .memWe(obsB.memWe), .memAddr(obsB.memAddr),
    .memWData(obsB.memWData), .memByteEn(obsB.memByteEn),
    .memAck(memAck), .memRData(memRData),
    .stall(obsB.stall), .outValid(obsB.outValid),
    .outLoadData(obsB.outLoadData), .outResult(obsB.outResult),
    .outRd(obsB.outRd), .outRegWrite(obsB.outRegWrite),
    .outMisaligned(obsB.outMisaligned), .outBusError(obsB.outBusError),
    .debugState(obsB.dbg)
  );

  int vecCount = 0;
  int missCount = 0;

  // transaction-level model state, written by the driver only
  bit active = 1'b0;
  int cyc = 0;
  int doneCyc = 0;
  bit timedOut = 1'b0;

  // values captured by the compare process for literal pinning
  logic [31:0] pinLoadA, pinLoadB, pinAddr, pinWData;
  logic [3:0]  pinByteEn;
  logic        pinWe, pinRegWrite, pinBusErr;
  int          stallCount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expLoad(input logic [31:0] addr, input logic word,
                                          input logic [31:0] rd, input bit sext);
    logic [7:0] b;
    if (word) return rd;
    b = 8'(rd >> (8 * addr[1:0]));
    return (sext && b[7]) ? {24'hFFFFFF, b} : {24'h000000, b};
  endfunction

  function automatic logic [3:0] expByteEn(input logic [31:0] addr, input logic word);
    logic [3:0] one;
    one = 4'b0001;
    return word ? 4'b1111 : (one << addr[1:0]);
  endfunction

  function automatic logic [31:0] expWData(input logic [31:0] sd, input logic word);
    return word ? sd : {4{sd[7:0]}};
  endfunction

  task automatic checkObs(input obs_t o, input bit sext, input string tag);
    logic memOp, mis, acc, expStall, expValid, expReq, atDone;
    memOp  = inMemRead | inMemWrite;
    mis    = memOp & inWord & (inAddress[1:0] != 2'b00);
    acc    = memOp & ~mis;
    atDone = acc && (cyc == doneCyc);
    if (!acc)              begin expStall = 0; expValid = 1; expReq = 0; end
    else if (cyc == 0)     begin expStall = 1; expValid = 0; expReq = 0; end
    else if (cyc < doneCyc) begin expStall = 1; expValid = 0; expReq = 1; end
    else                   begin expStall = 0; expValid = 1; expReq = 0; end

    check({tag, ".stall"}, o.stall, expStall);
    check({tag, ".outValid"}, o.outValid, expValid);
    check({tag, ".memReq"}, o.memReq, expReq);
    check({tag, ".outMisaligned"}, o.outMisaligned, mis);
    check({tag, ".outBusError"}, o.outBusError, atDone && timedOut);
    if (expReq) begin
      check({tag, ".memWe"}, o.memWe, inMemWrite);
      check({tag, ".memAddr"}, o.memAddr, {inAddress[31:2], 2'b00});
      check({tag, ".memByteEn"}, o.memByteEn, expByteEn(inAddress, inWord));
      if (inMemWrite) check({tag, ".memWData"}, o.memWData, expWData(inStoreData, inWord));
    end
    if (expValid) begin
      check({tag, ".outResult"}, o.outResult, inAddress);
      check({tag, ".outRd"}, o.outRd, inRd);
      check({tag, ".outRegWrite"}, o.outRegWrite,
            inRegWrite & ~mis & ~inMemWrite & ~(acc & timedOut));
    end
    if (atDone && (timedOut || !inMemWrite))
      check({tag, ".outLoadData"}, o.outLoadData,
            timedOut ? 32'd0 : expLoad(inAddress, inWord, memRData, sext));
  endtask

  // scoreboard: one compare per falling edge while an instruction is held
  always @(negedge clock) begin
    if (active) begin
      checkObs(obsA, 1'b1, "A");
      checkObs(obsB, 1'b0, "B");
      stallCount = (cyc == 0) ? int'(obsA.stall) : stallCount + int'(obsA.stall);
      if (obsA.memReq) begin
        pinAddr = obsA.memAddr; pinByteEn = obsA.memByteEn;
        pinWData = obsA.memWData; pinWe = obsA.memWe;
      end
      if (obsA.outValid) begin
        pinLoadA = obsA.outLoadData; pinLoadB = obsB.outLoadData;
        pinRegWrite = obsA.outRegWrite; pinBusErr = obsA.outBusError;
      end
    end
  end

  // driver: hold one EX/MEM instruction until the stage consumes it.
  // ackAt = BUSY cycle (1-based) carrying memAck; 0 = never ack.
  task automatic apply(input logic [31:0] addr, input logic [31:0] sd,
                       input logic rdE, input logic wrE, input logic word,
                       input logic rw, input logic [4:0] rd,
                       input int ackAt, input logic [31:0] rdata, input bit strayAck);
    logic memOp, acc;
    inAddress = addr; inStoreData = sd; inMemRead = rdE; inMemWrite = wrE;
    inWord = word; inRegWrite = rw; inRd = rd; memRData = rdata; memAck = 1'b0;
    memOp = rdE | wrE;
    acc = memOp & ~(word & (addr[1:0] != 2'b00));
    if (!acc) begin doneCyc = 0; timedOut = 1'b0; end
    else if (ackAt >= 1 && ackAt <= TO) begin doneCyc = ackAt + 1; timedOut = 1'b0; end
    else begin doneCyc = TO + 1; timedOut = 1'b1; end
    cyc = 0;
    active = 1'b1;
    for (int c = 1; c <= doneCyc; c++) begin
      @(posedge clock); #1;
      cyc = c;
      memAck = (c == doneCyc) ? strayAck : (c == ackAt);
    end
    @(posedge clock); #1;
    memAck = 1'b0;
  endtask

  task automatic nop(input logic [31:0] addr, input logic [4:0] rd);
    apply(addr, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, rd, 0, 32'h0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset.memReq", obsA.memReq, 1'b0);
    check("reset.memWe", obsA.memWe, 1'b0);
    check("reset.memByteEn", obsA.memByteEn, 4'd0);
    check("reset.memAddr", obsA.memAddr, 32'd0);
    check("reset.memWData", obsA.memWData, 32'd0);
    check("reset.outLoadData", obsA.outLoadData, 32'd0);
    check("reset.outBusError", obsA.outBusError, 1'b0);
    check("reset.state", obsA.dbg, 2'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;

    nop(32'h0000_1234, 5'd7);

    // word load, ack in the last allowed BUSY cycle
    apply(32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 4, 32'hDEADBEEF, 1'b0);
    check("wl.memAddr", pinAddr, 32'h100);
    check("wl.byteEn", pinByteEn, 4'b1111);
    check("wl.stallCycles", stallCount, 5);
    check("wl.loadData", pinLoadA, 32'hDEADBEEF);
    check("wl.regWrite", pinRegWrite, 1'b1);

    apply(32'h103, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 1, 32'h80FF0011, 1'b0);
    check("bl.sext1", pinLoadA, 32'hFFFFFF80);
    check("bl.sext0", pinLoadB, 32'h00000080);

    apply(32'h202, 32'h0000_00AB, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 2, 32'h0, 1'b0);
    check("bs.memAddr", pinAddr, 32'h200);
    check("bs.byteEn", pinByteEn, 4'b0100);
    check("bs.wData", pinWData, 32'hABABABAB);
    check("bs.we", pinWe, 1'b1);
    check("bs.regWrite", pinRegWrite, 1'b0);

    apply(32'h106, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1, 32'h0, 1'b0);
    check("mis.stallCycles", stallCount, 0);
    check("mis.regWrite", pinRegWrite, 1'b0);

    apply(32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 0, 32'h5555AAAA, 1'b0);
    check("to.busError", pinBusErr, 1'b1);
    check("to.loadData", pinLoadA, 32'd0);
    check("to.stallCycles", stallCount, 5);
    check("to.regWrite", pinRegWrite, 1'b0);
    nop(32'h0000_0400, 5'd9);

    // byte load lane 1 with a stray ack during DONE
    apply(32'h41, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 3, 32'h0000A500, 1'b1);
    check("bl1.sext1", pinLoadA, 32'hFFFFFFA5);
    check("bl1.sext0", pinLoadB, 32'h000000A5);
    nop(32'h0000_0044, 5'd11);

    apply(32'h80, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 1, 32'hFFFF0000, 1'b0);
    check("rw.we", pinWe, 1'b1);
    check("rw.regWrite", pinRegWrite, 1'b0);
    apply(32'h44, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 1'b0, 5'd13, 2, 32'h0, 1'b0);
    apply(32'h12, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd14, 3, 32'h007F0000, 1'b0);
    check("bl2.sext1", pinLoadA, 32'h0000007F);

    // reset in the middle of BUSY, then a late ack
    active = 1'b0;
    inAddress = 32'h500; inMemRead = 1'b1; inMemWrite = 1'b0; inWord = 1'b1;
    inRegWrite = 1'b1; inRd = 5'd15;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("rst.busyReq", obsA.memReq, 1'b1);
    reset = 1'b0;
    #1;
    check("rst.reqDrop", obsA.memReq, 1'b0);
    check("rst.state", obsA.dbg, 2'd0);
    inMemRead = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    memAck = 1'b1; memRData = 32'h1111_2222;
    @(posedge clock); #1;
    memAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst.idleState", obsA.dbg, 2'd0);
      check("rst.idleValid", obsA.outValid, 1'b1);
      check("rst.idleReq", obsA.memReq, 1'b0);
      @(posedge clock); #1;
    end

    nop(32'h0000_0600, 5'd16);
    active = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
